bus_invert_decoder: RTL and testbench
=====================================

// Module: bus_invert_decoder
//
// PURPOSE
// - Receive side of the per-bit inversion path: accepts bus-invert-coded words
//   (data plus invert flag) and restores the true data.
// - Restore is done bitwise: one inverter node per bit, instantiated with a generate loop.
// - Output goes through a 2-entry registered buffer with valid/ready handshakes on both sides.
// - Sits between the inverting transmitter and any downstream consumer.
//
// PARAMETERS
// - WIDTH   8   data width in bits, >= 1
// - CNT_W   16  width of the delivered-word counter (and inversion counter if enabled)
//
// PORTS
// - clk        in   1        single clock, rising edge
// - reset_n    in   1        asynchronous, active-low reset
// - in_valid   in   1        upstream word present
// - in_ready   out  1        decoder can accept a word this cycle
// - in_data    in   WIDTH    coded data
// - in_inv     in   1        1 = in_data is inverted; 0 = in_data is true data
// - out_valid  out  1        restored word available
// - out_ready  in   1        downstream accepts the word
// - out_data   out  WIDTH    restored data
// - word_cnt   out  CNT_W    count of words delivered (output handshakes)
// - inv_cnt    out  CNT_W    count of accepted words with in_inv=1 (BUS_INVERT_STATS_EN only)
//
// BEHAVIOUR
// - Reset values (asynchronous, while reset_n=0):
//   state=EMPTY, in_ready=1, out_valid=0, out_data=0, word_cnt=0, inv_cnt=0.
// - Reset mid-operation drops all buffered words immediately; no partial output.
// - Decode: restored = in_data ^ {WIDTH{in_inv}}, computed per bit at the input.
//   The buffer stores restored data only.
// - Push: in_valid & in_ready. Pop: out_valid & out_ready.
// - Latency: a word pushed in cycle N appears on out_data with out_valid=1 in cycle N+1.
// - in_ready is registered: 1 in EMPTY and ONE, 0 in FULL.
//   It never depends combinationally on out_ready.
// - out_valid is registered: 1 in ONE and FULL.
// - Head-of-line word and out_data stay stable while out_valid=1 and out_ready=0.
// - Order is strict FIFO; no word is ever dropped or duplicated.
// - States and transitions:
//   - EMPTY: push -> ONE; otherwise stay.
//   - ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE (new word becomes head
//     next cycle); neither -> ONE.
//   - FULL: pop -> ONE (second entry becomes head); no pop -> FULL. Push is impossible
//     because in_ready=0; in_valid is ignored.
// - word_cnt: +1 per pop, modulo 2^CNT_W (wraps to 0 from all-ones).
// - in_valid=1 with in_ready=0: no effect; upstream must hold the word.
//
// CONFIGURATION
// - BUS_INVERT_STATS_EN defined:
//   - inv_cnt port exists.
//   - inv_cnt +1 on each push with in_inv=1, modulo 2^CNT_W.
//   - Reset value 0.
// - BUS_INVERT_STATS_EN undefined:
//   - inv_cnt port and its counter logic are absent.
//   - All other behaviour is identical.
//
// TESTING
// - Reset, then push 8'hA5 inv=0, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5;
//   word_cnt=1 after pop.
// - Push 8'h0F inv=1 -> out_data=8'hF0; with STATS_EN, inv_cnt increments to 1.
// - out_ready=0, push 8'h01, 8'h02 -> in_ready=0 after 2nd push, 8'h03 held upstream;
//   release -> outputs 01, 02, 03 in order.
// - ONE state, push 8'h11 while popping 8'h10 each cycle for 20 cycles -> 1 word/cycle,
//   in_ready stays 1, order preserved.
// - CNT_W=4: deliver 17 words -> word_cnt goes 15 -> 0 -> 1.
// - FULL, assert reset_n=0 mid-cycle -> out_valid=0, in_ready=1, counts 0 at once;
//   no stale word after release.

Source files
------------

// File: rtl/bus_invert_decoder.sv
// rtl/bus_invert_decoder.sv - bus-invert receive decoder with 2-entry output buffer
//
// Purpose: restores true data from bus-invert-coded words (data ^ {WIDTH{inv}})
// and delivers them through a 2-entry registered FIFO with valid/ready on both sides.
// Optional feature macro: BUS_INVERT_STATS_EN (adds inv_cnt port and counter).
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      upstream word present
//   in_ready   out  1      decoder accepts a word this cycle (registered)
//   in_data    in   WIDTH  coded data
//   in_inv     in   1      1 = in_data is inverted
//   out_valid  out  1      restored word available (registered)
//   out_ready  in   1      downstream accepts the word
//   out_data   out  WIDTH  restored data (head of buffer)
//   word_cnt   out  CNT_W  words delivered, wraps
//   inv_cnt    out  CNT_W  accepted words with in_inv=1 (BUS_INVERT_STATS_EN only)
module bus_invert_decoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] word_cnt
`ifdef BUS_INVERT_STATS_EN
  ,
  output logic [CNT_W-1:0] inv_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] restored;
  logic [WIDTH-1:0] tail_q;
  logic             push;
  logic             pop;
  logic             load_head_in;
  logic             load_head_tail;
  logic             load_tail;

  // One inverter node per bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_restore
    assign restored[gi] = in_data[gi] ^ in_inv;
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // out_data is the head register itself, so it is stable while stalled.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d      = ST_ONE;
          load_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        case ({push, pop})
          2'b10: begin
            state_d   = ST_FULL;
            load_tail = 1'b1;
          end
          2'b01: state_d = ST_EMPTY;
          // Head leaves and the incoming word replaces it directly.
          2'b11: load_head_in = 1'b1;
          default: state_d = ST_ONE;
        endcase
      end
      ST_FULL: begin
        // in_ready is 0 here, so push cannot occur.
        if (pop) begin
          state_d        = ST_ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      tail_q    <= '0;
      word_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      // Handshake flags are registered copies of the next-state decode.
      in_ready  <= (state_d != ST_FULL);
      out_valid <= (state_d != ST_EMPTY);
      if (load_head_in) begin
        out_data <= restored;
      end else if (load_head_tail) begin
        out_data <= tail_q;
      end
      if (load_tail) begin
        tail_q <= restored;
      end
      if (pop) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

`ifdef BUS_INVERT_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inv_cnt <= '0;
    end else if (push && in_inv) begin
      inv_cnt <= inv_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bus_invert_decoder.sv
// tb/tb_bus_invert_decoder.sv - self-checking bench for bus_invert_decoder
module tb_bus_invert_decoder;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_inv;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] word_cnt;
`ifdef BUS_INVERT_STATS_EN
  logic [CNT_W-1:0] inv_cnt;
`endif

  int errors;
  int checks;

  bus_invert_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .word_cnt  (word_cnt)
`ifdef BUS_INVERT_STATS_EN
    ,
    .inv_cnt   (inv_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] din;
    logic       inv;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [3:0] e_wc;
    logic [3:0] e_ic;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ic(input logic [3:0] exp);
`ifdef BUS_INVERT_STATS_EN
    chk("inv_cnt", 32'(inv_cnt), 32'(exp));
`else
    if (exp === 4'hx) chk("inv_cnt_unused", 32'(exp), 32'(exp));
`endif
  endtask

  logic [7:0] prev;
  logic [7:0] v;
  logic [3:0] exp_wc;
  logic [3:0] exp_ic;
  logic       saw_wrap;

  initial begin
    errors   = 0;
    checks   = 0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_inv   = 1'b0;
    out_ready = 1'b0;

    //          iv  din    inv ordy  ir  ov  od     wc  ic
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 4'd0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 4'd0};
    vecs[2]  = '{1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 4'd0, 4'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hF0, 4'd1, 4'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd2, 4'd1};
    vecs[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd2, 4'd1};
    vecs[6]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'd2, 4'd1};
    vecs[7]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 4'd2, 4'd1};
    vecs[8]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 4'd2, 4'd1};
    vecs[9]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 4'd3, 4'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 4'd4, 4'd1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 4'd4, 4'd1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 4'd4, 4'd1};
    vecs[13] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd5, 4'd1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 4'd5, 4'd2};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 4'd5, 4'd2};

    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_word_cnt", 32'(word_cnt), 32'd0);
    chk_ic(4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].din;
      in_inv    = vecs[i].inv;
      out_ready = vecs[i].ordy;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov)
        chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      chk($sformatf("v%0d_word_cnt", i), 32'(word_cnt), 32'(vecs[i].e_wc));
      chk_ic(vecs[i].e_ic);
      step();
    end
    // last vector popped 8'hAA -> empty, 6 words delivered
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("tbl_end_out_valid", 32'(out_valid), 32'd0);
    exp_wc = 4'd6;
    exp_ic = 4'd2;
    chk("tbl_end_word_cnt", 32'(word_cnt), 32'(exp_wc));

    // Streaming in ONE: push+pop every cycle, crosses the 15 -> 0 wrap.
    in_valid  = 1'b1;
    in_data   = 8'h10;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    step();
    prev = 8'h10;
    saw_wrap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      v = 8'h11 + 8'(i);
      in_inv  = i[0];
      in_data = i[0] ? ~v : v;
      chk($sformatf("st%0d_in_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("st%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("st%0d_out_data", i), 32'(out_data), 32'(prev));
      chk($sformatf("st%0d_word_cnt", i), 32'(word_cnt), 32'(exp_wc));
      step();
      if (exp_wc == 4'hF) saw_wrap = 1'b1;
      exp_wc = exp_wc + 4'd1;
      if (i[0]) exp_ic = exp_ic + 4'd1;
      prev = v;
    end
    in_valid = 1'b0;
    chk("st_tail_out_data", 32'(out_data), 32'(prev));
    chk("st_wrap_seen", 32'(saw_wrap), 32'd1);
    step();
    exp_wc = exp_wc + 4'd1;
    chk("st_end_word_cnt", 32'(word_cnt), 32'(exp_wc));
    chk("st_end_out_valid", 32'(out_valid), 32'd0);
    chk_ic(exp_ic);

    // Fill to FULL, then asynchronous reset mid-cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inv    = 1'b1;
    in_data   = 8'h3C;
    step();
    in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_data", 32'(out_data), 32'hC3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk_ic(4'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_inv   = 1'b0;
    in_data  = 8'h77;
    step();
    in_valid = 1'b0;
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_out_data", 32'(out_data), 32'h77);
    step();
    chk("post_rst_word_cnt", 32'(word_cnt), 32'd1);
    chk("post_rst_drain", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
